// File: rtl/divider_unit_if.sv
// Operand/result bundle for divider_unit: the start level and operands come in,
// and the registered results and status flags go out.
interface divider_unit_if #(
  parameter int WIDTH = 8
);
  logic             Run;
  logic [WIDTH-1:0] Dividend;
  logic [WIDTH-1:0] Divisor;
  logic [WIDTH-1:0] Quotient;
  logic [WIDTH-1:0] Remainder;
  logic             Busy;
  logic             Done;
  logic             Div_By_Zero;

  modport master (
    output Run, Dividend, Divisor,
    input  Quotient, Remainder, Busy, Done, Div_By_Zero
  );

  modport slave (
    input  Run, Dividend, Divisor,
    output Quotient, Remainder, Busy, Done, Div_By_Zero
  );
endinterface

// File: rtl/divider_unit.sv
// Sequential restoring divider that produces one quotient bit per clock.
// Define SIGNED_DIV_EN for two's-complement operands; this adds a sign FIXUP state.
module divider_unit #(
  parameter int WIDTH = 8
) (
  input logic           Clk,
  input logic           Reset,
  divider_unit_if.slave bus
);

  localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;

`ifdef SIGNED_DIV_EN
  typedef enum logic [1:0] {IDLE, CALC, FIXUP, DONE} state_t;
`else
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
`endif

  state_t state, next_state;

  logic [WIDTH-1:0] r, q, m;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] quotient_r, remainder_r;
  logic             busy_r, dz_r;

  logic [2*WIDTH-1:0] rq_sh;
  logic [WIDTH:0]     trial;
  logic [WIDTH-1:0]   r_next, q_next;
  logic               last_iter;
  logic               start, div_zero;
  logic [WIDTH-1:0]   dvd_load, dvs_load;

`ifdef SIGNED_DIV_EN
  logic neg_q, neg_r;
  // CALC always works on magnitudes; the signs are reapplied in FIXUP.
  assign dvd_load = bus.Dividend[WIDTH-1] ? WIDTH'(-bus.Dividend) : bus.Dividend;
  assign dvs_load = bus.Divisor[WIDTH-1]  ? WIDTH'(-bus.Divisor)  : bus.Divisor;
`else
  assign dvd_load = bus.Dividend;
  assign dvs_load = bus.Divisor;
`endif

  assign start     = bus.Run;
  assign div_zero  = (bus.Divisor == '0);
  assign last_iter = (cnt == CNT_W'(WIDTH - 1));

  // One restoring step: shift {R,Q}, then keep the trial difference if it did not borrow.
  always_comb begin
    rq_sh  = {r, q} << 1;
    trial  = {1'b0, rq_sh[2*WIDTH-1:WIDTH]} - {1'b0, m};
    r_next = rq_sh[2*WIDTH-1:WIDTH];
    q_next = rq_sh[WIDTH-1:0];
    if (!trial[WIDTH]) begin
      r_next = trial[WIDTH-1:0];
      q_next = rq_sh[WIDTH-1:0] | WIDTH'(1);
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: if (start) next_state = div_zero ? DONE : CALC;
`ifdef SIGNED_DIV_EN
      CALC:  if (last_iter) next_state = FIXUP;
      FIXUP: next_state = DONE;
`else
      CALC: if (last_iter) next_state = DONE;
`endif
      DONE: if (!start) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    bus.Done        = (state == DONE);
    bus.Div_By_Zero = (state == DONE) && dz_r;
  end

  assign bus.Quotient  = quotient_r;
  assign bus.Remainder = remainder_r;
  assign bus.Busy      = busy_r;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r           <= '0;
      q           <= '0;
      m           <= '0;
      cnt         <= '0;
      quotient_r  <= '0;
      remainder_r <= '0;
      busy_r      <= 1'b0;
      dz_r        <= 1'b0;
`ifdef SIGNED_DIV_EN
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            m   <= dvs_load;
            q   <= dvd_load;
            r   <= '0;
            cnt <= '0;
`ifdef SIGNED_DIV_EN
            neg_q <= bus.Dividend[WIDTH-1] ^ bus.Divisor[WIDTH-1];
            neg_r <= bus.Dividend[WIDTH-1];
`endif
            if (div_zero) begin
              quotient_r  <= '1;
              remainder_r <= bus.Dividend;
              dz_r        <= 1'b1;
            end else begin
              busy_r <= 1'b1;
            end
          end
        end
        CALC: begin
          r   <= r_next;
          q   <= q_next;
          cnt <= cnt + CNT_W'(1);
`ifndef SIGNED_DIV_EN
          if (last_iter) begin
            quotient_r  <= q_next;
            remainder_r <= r_next;
            dz_r        <= 1'b0;
            busy_r      <= 1'b0;
          end
`endif
        end
`ifdef SIGNED_DIV_EN
        FIXUP: begin
          quotient_r  <= neg_q ? WIDTH'(-q) : q;
          remainder_r <= neg_r ? WIDTH'(-r) : r;
          dz_r        <= 1'b0;
          busy_r      <= 1'b0;
        end
`endif
        default: ;
      endcase
    end
  end

endmodule
